// File: rtl/burst_pkg.sv
// Shared constants and width helpers for the online-arithmetic output path.
package burst_pkg;

  localparam int unsigned DEFAULT_NO_OF_DIGITS = 8;
  localparam int unsigned DEFAULT_RADIX_BITS   = 3;
  localparam int unsigned DEFAULT_BURST_INDEX  = 8;
  localparam int unsigned BEAT_CNT_BITS        = 4;

  // A digit vector carries one guard digit beyond the result digits.
  function automatic int unsigned calc_no_of_bits(input int unsigned digits,
                                                  input int unsigned rbits);
    return (digits + 1) * rbits;
  endfunction

  function automatic int unsigned calc_word_width(input int unsigned nbits,
                                                  input int unsigned beats);
    return nbits * beats;
  endfunction

  localparam int unsigned DEFAULT_NO_OF_BITS =
    calc_no_of_bits(DEFAULT_NO_OF_DIGITS, DEFAULT_RADIX_BITS);
  localparam int unsigned DEFAULT_WORD_WIDTH =
    calc_word_width(DEFAULT_NO_OF_BITS, DEFAULT_BURST_INDEX);

endpackage

// File: rtl/burst_word_fifo.sv
// Two-entry first-word-first-out buffer; dout is the registered head entry.
module burst_word_fifo
  import burst_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WORD_WIDTH
) (
  input  logic             variable_clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [width-1:0] tail_q;
  logic [1:0]       count_q;
  logic [width-1:0] head_n;
  logic [width-1:0] tail_n;
  logic [1:0]       count_n;
  logic             pop_ok_c;
  logic             push_ok_c;

  // A push into a full buffer is accepted only when the head leaves at the same edge.
  assign pop_ok_c  = pop & ~empty;
  assign push_ok_c = push & (~full | pop_ok_c);

  always_comb begin
    head_n  = dout;
    tail_n  = tail_q;
    count_n = count_q;
    unique case ({push_ok_c, pop_ok_c})
      2'b10: begin
        if (empty) head_n = din;
        else       tail_n = din;
        count_n = count_q + 2'd1;
      end
      2'b01: begin
        if (full) head_n = tail_q;
        count_n = count_q - 2'd1;
      end
      2'b11: begin
        if (full) begin
          head_n = tail_q;
          tail_n = din;
        end else begin
          head_n = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge variable_clk or negedge reset_n) begin
    if (!reset_n) begin
      dout    <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else if (clear) begin
      dout    <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      dout    <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      empty   <= (count_n == 2'd0);
      full    <= (count_n == 2'd2);
    end
  end

endmodule

// File: rtl/burst_mem_writer.sv
// Packs burst_index valid digit vectors per memory word and writes them out
// through a 2-entry FIFO with an auto-incrementing address.
module burst_mem_writer
  import burst_pkg::*;
#(
  parameter int unsigned no_of_digits = DEFAULT_NO_OF_DIGITS,
  parameter int unsigned radix_bits   = DEFAULT_RADIX_BITS,
  parameter int unsigned burst_index  = DEFAULT_BURST_INDEX,
  parameter int unsigned addr_bits    = 6,
  parameter int unsigned max_words    = 64,
  localparam int unsigned no_of_bits  = calc_no_of_bits(no_of_digits, radix_bits),
  localparam int unsigned word_bits   = calc_word_width(no_of_bits, burst_index)
) (
  input  logic                  variable_clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [no_of_bits-1:0] Dout,
  input  logic                  dout_valid,
  output logic [word_bits-1:0]  mem_wdata,
  output logic [addr_bits-1:0]  mem_addr,
  output logic                  mem_wr_en,
  input  logic                  mem_ready,
  output logic [addr_bits:0]    words_written,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned low_bits = (burst_index - 1) * no_of_bits;
  localparam int unsigned cnt_bits = addr_bits + 1;
  localparam logic [BEAT_CNT_BITS-1:0] last_beat = BEAT_CNT_BITS'(burst_index - 1);
  localparam logic [addr_bits:0]       max_count = cnt_bits'(max_words);

  logic [BEAT_CNT_BITS-1:0] beat_cnt;
  logic [word_bits-1:0]     shift_reg;
  logic [word_bits-1:0]     word_c;
  logic                     accept_c;
  logic                     last_c;
  logic                     pop_c;
  logic                     done_set_c;
  logic                     fifo_empty;
  logic                     fifo_full;

  assign accept_c   = dout_valid & ~done;
  assign last_c     = accept_c & (beat_cnt == last_beat);
  assign word_c     = {shift_reg[low_bits-1:0], Dout};
  assign mem_wr_en  = ~fifo_empty;
  assign pop_c      = mem_wr_en & mem_ready;
  assign done_set_c = pop_c & ~done & (words_written == max_count - cnt_bits'(1));

  // Beat framing; a partial burst is discarded once the write quota is reached.
  always_ff @(posedge variable_clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      shift_reg <= '0;
    end else if (clear || done_set_c) begin
      beat_cnt  <= '0;
      shift_reg <= '0;
    end else if (accept_c) begin
      shift_reg <= word_c;
      beat_cnt  <= last_c ? '0 : beat_cnt + BEAT_CNT_BITS'(1);
    end
  end

  // Write-side bookkeeping: address, accepted count, drop flag and completion.
  always_ff @(posedge variable_clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr      <= '0;
      words_written <= '0;
      overflow      <= 1'b0;
      done          <= 1'b0;
    end else if (clear) begin
      mem_addr      <= '0;
      words_written <= '0;
      overflow      <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (pop_c) begin
        mem_addr <= mem_addr + addr_bits'(1);
        if (words_written != max_count) words_written <= words_written + cnt_bits'(1);
      end
      if (last_c && fifo_full && !pop_c) overflow <= 1'b1;
      if (done_set_c) done <= 1'b1;
    end
  end

  burst_word_fifo #(
    .width(word_bits)
  ) u_fifo (
    .variable_clk(variable_clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .push        (last_c),
    .pop         (pop_c),
    .din         (word_c),
    .dout        (mem_wdata),
    .empty       (fifo_empty),
    .full        (fifo_full)
  );

endmodule

// File: tb/tb_burst_mem_writer.sv
// Bench for burst_mem_writer: table-driven bursts plus backpressure, reset and wrap sequences.
module tb_burst_mem_writer;
  import burst_pkg::*;

  localparam int unsigned N = 27;
  localparam int unsigned B = 8;
  localparam int unsigned W = N * B;

  logic variable_clk = 1'b0;
  always #5 variable_clk = ~variable_clk;

  logic         reset_n, reset_n_w, clear, dout_valid, mem_ready;
  logic [N-1:0] Dout;

  logic [W-1:0] mem_wdata, mem_wdata_w;
  logic [5:0]   mem_addr;
  logic [1:0]   mem_addr_w;
  logic         mem_wr_en, mem_wr_en_w;
  logic [6:0]   words_written;
  logic [2:0]   words_written_w;
  logic         overflow, overflow_w, done, done_w;

  burst_mem_writer dut (
    .variable_clk(variable_clk), .reset_n(reset_n), .clear(clear),
    .Dout(Dout), .dout_valid(dout_valid), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_ready(mem_ready),
    .words_written(words_written), .overflow(overflow), .done(done)
  );

  burst_mem_writer #(.addr_bits(2), .max_words(4)) dut_w (
    .variable_clk(variable_clk), .reset_n(reset_n_w), .clear(clear),
    .Dout(Dout), .dout_valid(dout_valid), .mem_wdata(mem_wdata_w),
    .mem_addr(mem_addr_w), .mem_wr_en(mem_wr_en_w), .mem_ready(mem_ready),
    .words_written(words_written_w), .overflow(overflow_w), .done(done_w)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [5:0]   addr;
  } exp_t;

  typedef struct {
    int           base;
    bit           gapped;
    logic [N-1:0] exp_first;
    logic [N-1:0] exp_last;
  } vec_t;

  exp_t       sb_q[$];
  exp_t       sbw_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [5:0] exp_addr;
  logic [1:0] exp_addr_w;
  bit         mon_en;
  bit         mon_w_en;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int base);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < B; i++) w[(B-1-i)*N +: N] = N'(base + i);
    return w;
  endfunction

  // Scoreboard for the default-parameter instance.
  always @(negedge variable_clk) begin
    if (mon_en && mem_wr_en && mem_ready) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d with no expected word", mem_addr);
      end else begin
        e = sb_q.pop_front();
        check("write_data", mem_wdata, e.data);
        check("write_addr", W'(mem_addr), W'(e.addr));
      end
    end
  end

  // Scoreboard for the small-address instance.
  always @(negedge variable_clk) begin
    if (mon_w_en && mem_wr_en_w && mem_ready) begin
      exp_t e;
      if (sbw_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write_w: got addr %0d with no expected word", mem_addr_w);
      end else begin
        e = sbw_q.pop_front();
        check("write_data_w", mem_wdata_w, e.data);
        check("write_addr_w", W'(mem_addr_w), W'(e.addr));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge variable_clk);
      #1;
    end
  endtask

  task automatic beat(input int v);
    Dout       = N'(v);
    dout_valid = 1'b1;
    @(posedge variable_clk);
    #1;
    dout_valid = 1'b0;
  endtask

  task automatic burst(input int base, input bit gapped, input bit exp_main,
                       input bit exp_w, input bit ready_on_last);
    for (int i = 0; i < B; i++) begin
      if (i == B - 1) begin
        if (exp_main) begin
          sb_q.push_back('{pack(base), exp_addr});
          exp_addr = exp_addr + 6'd1;
        end
        if (exp_w) begin
          sbw_q.push_back('{pack(base), 6'(exp_addr_w)});
          exp_addr_w = exp_addr_w + 2'd1;
        end
        if (ready_on_last) mem_ready = 1'b1;
      end
      beat(base + i);
      if (i == B - 1 && ready_on_last) mem_ready = 1'b0;
      if (gapped && i != B - 1) idle(1);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"},    W'(mem_wr_en), W'(0));
    check({tag, "_wdata"},    mem_wdata, '0);
    check({tag, "_addr"},     W'(mem_addr), W'(0));
    check({tag, "_written"},  W'(words_written), W'(0));
    check({tag, "_overflow"}, W'(overflow), W'(0));
    check({tag, "_done"},     W'(done), W'(0));
  endtask

  task automatic main_reset();
    reset_n = 1'b0;
    sb_q.delete();
    exp_addr = '0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{1,   1'b0, 27'd1,   27'd8};
    vecs[1] = '{1,   1'b1, 27'd1,   27'd8};
    vecs[2] = '{20,  1'b1, 27'd20,  27'd27};
    vecs[3] = '{100, 1'b0, 27'd100, 27'd107};

    reset_n = 1'b0; reset_n_w = 1'b0; clear = 1'b0;
    dout_valid = 1'b0; Dout = '0; mem_ready = 1'b1;
    mon_en = 1'b1; mon_w_en = 1'b0;
    exp_addr = '0; exp_addr_w = '0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    check_zero("reset");

    // Single bursts, contiguous and gapped, one-cycle write latency.
    for (int i = 0; i < 4; i++) begin
      burst(vecs[i].base, vecs[i].gapped, 1'b1, 1'b0, 1'b0);
      check("tbl_wr_en", W'(mem_wr_en), W'(1));
      check("tbl_first_slice", W'(mem_wdata[W-1 -: N]), W'(vecs[i].exp_first));
      check("tbl_last_slice",  W'(mem_wdata[N-1:0]),    W'(vecs[i].exp_last));
      idle(1);
      check("tbl_wr_en_after", W'(mem_wr_en), W'(0));
      check("tbl_addr_after",  W'(mem_addr), W'(i + 1));
    end

    // Backpressure: two words buffered, third dropped.
    mem_ready = 1'b0;
    burst(200, 1'b0, 1'b1, 1'b0, 1'b0);
    burst(300, 1'b0, 1'b1, 1'b0, 1'b0);
    burst(400, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_overflow", W'(overflow), W'(1));
    check("bp_wr_en",    W'(mem_wr_en), W'(1));
    check("bp_hold_data", mem_wdata, pack(200));
    check("bp_hold_addr", W'(mem_addr), W'(4));
    mem_ready = 1'b1;
    idle(3);
    check("bp_drained",      W'(mem_wr_en), W'(0));
    check("bp_overflow_held", W'(overflow), W'(1));
    check("bp_addr_end",     W'(mem_addr), W'(6));
    check("bp_written",      W'(words_written), W'(6));
    check("bp_sb_empty",     W'(sb_q.size()), W'(0));

    // Full FIFO with a pop on the same edge as the third push.
    main_reset();
    mem_ready = 1'b0;
    burst(10, 1'b0, 1'b1, 1'b0, 1'b0);
    burst(40, 1'b0, 1'b1, 1'b0, 1'b0);
    burst(70, 1'b0, 1'b1, 1'b0, 1'b1);
    check("fp_overflow", W'(overflow), W'(0));
    check("fp_head",     mem_wdata, pack(40));
    check("fp_written1", W'(words_written), W'(1));
    mem_ready = 1'b1;
    idle(3);
    check("fp_written3", W'(words_written), W'(3));
    check("fp_overflow_end", W'(overflow), W'(0));
    check("fp_sb_empty", W'(sb_q.size()), W'(0));

    // Mid-burst reset, then mid-burst clear (asserted alongside a valid beat).
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) beat(50 + i);
      if (k == 0) begin
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
      end else begin
        clear = 1'b1;
        Dout = N'(999);
        dout_valid = 1'b1;
        idle(1);
        clear = 1'b0;
        dout_valid = 1'b0;
      end
      sb_q.delete();
      exp_addr = '0;
      check_zero(k == 0 ? "midrst" : "midclr");
      burst(150 + k * 100, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      check("restart_written", W'(words_written), W'(1));
      check("restart_addr",    W'(mem_addr), W'(1));
      check("restart_sb_empty", W'(sb_q.size()), W'(0));
    end

    // Termination and address wrap on the small instance.
    mon_en = 1'b0;
    reset_n_w = 1'b1;
    idle(1);
    mon_w_en = 1'b1;
    mem_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      burst(500 + j * 10, 1'b0, 1'b0, j < 4, 1'b0);
      idle(2);
      if (j == 2) check("wrap_done_early", W'(done_w), W'(0));
      if (j == 3) check("wrap_done_set", W'(done_w), W'(1));
    end
    check("wrap_done",    W'(done_w), W'(1));
    check("wrap_written", W'(words_written_w), W'(4));
    check("wrap_addr",    W'(mem_addr_w), W'(0));
    check("wrap_no_write", W'(mem_wr_en_w), W'(0));
    check("wrap_overflow", W'(overflow_w), W'(0));
    check("wrap_sb_empty", W'(sbw_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_mem_writer.md
Name: burst_mem_writer

Overview:
- Downstream stage of the online-arithmetic output path. It takes the per-cycle output digit vector Dout and packs burst_index consecutive valid digit vectors into one memory word.
- Completed words are buffered in a 2-entry FIFO and written to an on-chip result memory through a valid/ready write port with an auto-incrementing address.
- Unlike the free-running shift packer, it frames bursts with an explicit beat counter, tracks completion, and flags dropped words.

Parameters:
- no_of_digits, 8, digits per result (the digit vector carries no_of_digits+1 digits).
- radix_bits, 3, bits per digit.
- burst_index, 8, digit vectors per memory word (2..15).
- addr_bits, 6, memory address width.
- max_words, 64, words written before done asserts (1..2^addr_bits).
- Derived localparam no_of_bits = (no_of_digits+1)*radix_bits.

Ports:
- variable_clk, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- clear, in, 1, synchronous restart; same effect as reset.
- Dout, in, no_of_bits, digit vector from the online arithmetic core.
- dout_valid, in, 1, Dout carries a valid beat this cycle.
- mem_wdata, out, no_of_bits*burst_index, word presented to memory.
- mem_addr, out, addr_bits, write address for mem_wdata.
- mem_wr_en, out, 1, write request; high while the FIFO is non-empty.
- mem_ready, in, 1, memory accepts the write this cycle.
- words_written, out, addr_bits+1, count of accepted writes.
- overflow, out, 1, sticky; a completed word was dropped.
- done, out, 1, max_words writes have been accepted.

Behaviour:
- Reset (async, reset_n=0) and clear=1 (sync) both zero all of the following: beat counter, shift register, FIFO pointers and occupancy, mem_addr, words_written, overflow, done.
- After reset, mem_wr_en=0 and mem_wdata=0. clear has priority over every other event in the same cycle.
- Beat accept: a beat is accepted when dout_valid=1 and done=0. When done=1, dout_valid is ignored.
- Packing: shift_reg <= {shift_reg[lower (burst_index-1)*no_of_bits bits], Dout}.
  - The first beat of a burst ends up in the MSB slice. The last beat sits in the LSB slice.
- Beat counter: runs 0..burst_index-1 and increments per accepted beat. On the accepted beat with counter==burst_index-1:
  - the completed word {shift_reg lower slice, Dout} is pushed into the FIFO at that same edge;
  - the counter returns to 0.
- Latency: if the last beat is accepted at edge N, then mem_wr_en=1 and mem_wdata=that word after edge N, provided the FIFO was empty.
- FIFO: 2 entries, first-word-first-out.
  - Pop when mem_wr_en && mem_ready.
  - mem_wdata always shows the head entry. mem_wdata and mem_addr hold stable while mem_wr_en=1 and mem_ready=0.
- Simultaneous push and pop:
  - FIFO full: the push is accepted because the pop frees a slot at the same edge; occupancy stays 2.
  - FIFO empty: no pass-through; the word becomes the head after the edge.
- Full with no pop: the completed word is dropped and overflow is set and held until reset or clear. Packing continues normally.
- Address: mem_addr increments by 1 on each pop and wraps from 2^addr_bits-1 to 0. words_written increments on each pop.
- done is set at the edge where words_written reaches max_words.
  - Words still in the FIFO drain normally.
  - done does not block further pops.
  - words_written saturates at max_words.
  - A partial burst in progress when done sets is discarded.
- Reset mid-operation: the partial burst and FIFO contents are lost. No write is issued after reset until a new full burst completes.

Decomposition:
- Shared package burst_pkg holds:
  - the no_of_bits derivation function;
  - the word-width constant;
  - default radix_bits and burst_index, shared with the existing concatenation stage.
- One sub-module: burst_word_fifo, a 2-entry synchronous FIFO.
  - Parameter: width. Ports: push, pop, din, dout, empty, full.
  - Implements the push-when-full-with-pop rule.

Test Plan:
- Single burst, defaults: 8 valid beats Dout=1..8, mem_ready=1 → mem_wr_en high 1 cycle after beat 8; mem_wdata slice[215:189]=1, slice[26:0]=8; mem_addr=0, then 1 after the write.
- Gapped valid: 8 beats with dout_valid toggling every other cycle → identical word to the contiguous case; counter does not advance on invalid cycles.
- Backpressure: mem_ready=0, 3 bursts → FIFO holds words 1 and 2, word 3 dropped, overflow=1. Then mem_ready=1 → exactly 2 writes at addresses 0 and 1; overflow stays 1.
- Full plus simultaneous pop: FIFO full, mem_ready pulses high exactly at the edge burst 3 completes → no drop, overflow=0, 3 writes total in order.
- Termination and wrap: addr_bits=2, max_words=4, 5 bursts → addresses 0,1,2,3; done=1 after the 4th write; 5th burst ignored; words_written=4.
- Reset and clear: reset_n low after beat 5 of a burst → all outputs 0. Then 8 new beats → a single word containing only the post-reset beats. Repeat using clear with the same result.
